// File: rtl/ota_pkg.sv
// rtl/ota_pkg.sv - shared types and widths for the over-temperature alarm controller
package ota_pkg;
   typedef enum logic [1:0] {IDLE, ARMING, ALARM, ACKED} ota_state_t;
   localparam int SENSOR_ID_W = 16;
   localparam int RUN_W       = 8;
endpackage

// File: rtl/overtemp_alarm_ctrl_if.sv
// rtl/overtemp_alarm_ctrl_if.sv - sample/ack inputs and alarm outputs of the alarm controller
interface overtemp_alarm_ctrl_if
   import ota_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic                   sample_valid;
   logic                   over_temp;
   logic [SENSOR_ID_W-1:0] sensor_id;
   logic                   ack;
   logic                   alarm;
   logic [SENSOR_ID_W-1:0] alarm_id;
   logic                   irq;
   logic [CNT_W-1:0]       event_count;
   logic                   shutdown;

   modport master (
      output sample_valid, over_temp, sensor_id, ack,
      input  alarm, alarm_id, irq, event_count, shutdown
   );

   modport slave (
      input  sample_valid, over_temp, sensor_id, ack,
      output alarm, alarm_id, irq, event_count, shutdown
   );
endinterface

// File: rtl/ota_run_counter.sv
// rtl/ota_run_counter.sv - run-length counter with sync clear, enable and terminal compare
module ota_run_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         at_term
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   assign at_term = (cnt == term);
endmodule

// File: rtl/overtemp_alarm_ctrl.sv
// rtl/overtemp_alarm_ctrl.sv - debounced over-temperature alarm with ack, release run and event count
// Optional OTA_TIMEOUT_EN: escalate an unacknowledged alarm to a sticky shutdown request.
module overtemp_alarm_ctrl
   import ota_pkg::*;
#(
   parameter int ASSERT_CNT  = 4,
   parameter int CLEAR_CNT   = 8,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                  clk,
   input  logic                  rstn,
   overtemp_alarm_ctrl_if.slave  bus
);
   if (ASSERT_CNT < 2 || ASSERT_CNT > 255 || CLEAR_CNT < 1 || CLEAR_CNT > 255 ||
       CNT_W < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("overtemp_alarm_ctrl: parameter out of legal range");
   end

   ota_state_t             state;
   logic                   alarm_q;
   logic                   irq_q;
   logic [SENSOR_ID_W-1:0] alarm_id_q;
   logic [CNT_W-1:0]       event_count_q;
   logic                   hit_term;
   logic                   clr_term;

   logic acc_hot, acc_cool, enter_alarm;
   assign acc_hot     = bus.sample_valid &  bus.over_temp;
   assign acc_cool    = bus.sample_valid & ~bus.over_temp;
   assign enter_alarm = (state == ARMING) & acc_hot & hit_term;

   ota_run_counter #(.W(RUN_W)) u_hit (
      .clk     (clk),
      .rstn    (rstn),
      .clr     ((state == ARMING) & (acc_cool | (acc_hot & hit_term))),
      .en      (acc_hot & ((state == IDLE) | (state == ARMING))),
      .term    (RUN_W'(ASSERT_CNT - 1)),
      .at_term (hit_term)
   );

   // ack in ALARM clears the release run even if a cool sample arrives alongside it
   ota_run_counter #(.W(RUN_W)) u_clr (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (((state == ALARM) & bus.ack) |
                ((state == ACKED) & (acc_hot | (acc_cool & clr_term)))),
      .en      ((state == ACKED) & acc_cool),
      .term    (RUN_W'(CLEAR_CNT - 1)),
      .at_term (clr_term)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= IDLE;
         alarm_q       <= 1'b0;
         irq_q         <= 1'b0;
         alarm_id_q    <= '0;
         event_count_q <= '0;
      end else begin
         irq_q <= 1'b0;
         case (state)
            IDLE: begin
               if (acc_hot) state <= ARMING;
            end
            ARMING: begin
               if (acc_cool) begin
                  state <= IDLE;
               end else if (enter_alarm) begin
                  state      <= ALARM;
                  alarm_q    <= 1'b1;
                  irq_q      <= 1'b1;
                  alarm_id_q <= bus.sensor_id;
                  if (event_count_q != '1) event_count_q <= event_count_q + CNT_W'(1);
               end
            end
            ALARM: begin
               if (bus.ack) state <= ACKED;
            end
            ACKED: begin
               if (acc_cool && clr_term) begin
                  state   <= IDLE;
                  alarm_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef OTA_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt;
   logic            shutdown_q;

   // counter parks at its last value once the request has been raised
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt     <= '0;
         shutdown_q <= 1'b0;
      end else begin
         if (enter_alarm) begin
            to_cnt <= '0;
         end else if (state == ALARM && !bus.ack && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (state == ALARM && !bus.ack && to_cnt == TO_LAST) shutdown_q <= 1'b1;
      end
   end

   assign bus.shutdown = shutdown_q;
`else
   assign bus.shutdown = 1'b0;
`endif

   assign bus.alarm       = alarm_q;
   assign bus.irq         = irq_q;
   assign bus.alarm_id    = alarm_id_q;
   assign bus.event_count = event_count_q;
endmodule

// File: tb/tb_overtemp_alarm_ctrl.sv
// tb/tb_overtemp_alarm_ctrl.sv - scoreboard bench for overtemp_alarm_ctrl (optional OTA_TIMEOUT_EN)
module tb_overtemp_alarm_ctrl;
   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   overtemp_alarm_ctrl_if #(.CNT_W(8)) bus ();

   overtemp_alarm_ctrl #(
      .ASSERT_CNT  (4),
      .CLEAR_CNT   (8),
      .CNT_W       (8),
      .TIMEOUT_CYC (10)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   typedef struct packed {
      logic [15:0] id;
      logic [7:0]  cnt;
   } exp_t;

   exp_t     exp_q[$];
   int       n_checks = 0;
   int       n_fail   = 0;
   int       exp_count = 0;

`ifdef OTA_TIMEOUT_EN
   localparam logic SD_AFTER_LONG = 1'b1;
`else
   localparam logic SD_AFTER_LONG = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic [15:0] id, input logic a);
      @(negedge clk);
      bus.sample_valid = v;
      bus.over_temp    = h;
      bus.sensor_id    = id;
      bus.ack          = a;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic push_alarm(input logic [15:0] id);
      exp_t e;
      exp_count = (exp_count == 255) ? 255 : exp_count + 1;
      e.id  = id;
      e.cnt = 8'(exp_count);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      bus.sample_valid = 1'b0;
      bus.over_temp    = 1'b0;
      bus.sensor_id    = 16'h0;
      bus.ack          = 1'b0;
      @(negedge clk);
      chk("rst_alarm",       32'(bus.alarm),       32'h0);
      chk("rst_irq",         32'(bus.irq),         32'h0);
      chk("rst_shutdown",    32'(bus.shutdown),    32'h0);
      chk("rst_alarm_id",    32'(bus.alarm_id),    32'h0);
      chk("rst_event_count", 32'(bus.event_count), 32'h0);
      exp_count = 0;
      rstn = 1'b1;
   endtask

   // three hot samples carrying a decoy id, then the completing one
   task automatic raise(input logic [15:0] id);
      repeat (3) drive(1'b1, 1'b1, ~id, 1'b0);
      push_alarm(id);
      drive(1'b1, 1'b1, id, 1'b0);
      idle();
      chk("raise_alarm", 32'(bus.alarm), 32'h1);
   endtask

   task automatic release_alarm(input logic do_ack);
      if (do_ack) drive(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (8) drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("release_alarm", 32'(bus.alarm), 32'h0);
   endtask

   // monitor: every irq pulse must match the next expected alarm event
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && bus.irq) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_irq: got irq=1 with no alarm expected at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("irq_alarm",       32'(bus.alarm),       32'h1);
               chk("irq_alarm_id",    32'(bus.alarm_id),    32'(e.id));
               chk("irq_event_count", 32'(bus.event_count), 32'(e.cnt));
            end
            @(negedge clk);
            if (rstn) chk("irq_one_cycle", 32'(bus.irq), 32'h0);
         end
      end
   end

   initial begin
      bus.sample_valid = 1'b0;
      bus.over_temp    = 1'b0;
      bus.sensor_id    = 16'h0;
      bus.ack          = 1'b0;
      do_reset();

      // basic raise; alarm must still be low after three samples
      repeat (3) drive(1'b1, 1'b1, 16'h00A5, 1'b0);
      idle();
      chk("t1_after3", 32'(bus.alarm), 32'h0);
      push_alarm(16'h00A5);
      drive(1'b1, 1'b1, 16'h00A5, 1'b0);
      idle();
      chk("t1_alarm", 32'(bus.alarm), 32'h1);
      release_alarm(1'b1);
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      idle();
      chk("ack_in_idle_alarm", 32'(bus.alarm),    32'h0);
      chk("alarm_id_held",     32'(bus.alarm_id), 32'h00A5);

      // broken run
      repeat (3) drive(1'b1, 1'b1, 16'h1111, 1'b0);
      drive(1'b1, 1'b0, 16'h1111, 1'b0);
      repeat (3) drive(1'b1, 1'b1, 16'h2222, 1'b0);
      idle();
      chk("t2_broken", 32'(bus.alarm), 32'h0);
      push_alarm(16'h0B0B);
      drive(1'b1, 1'b1, 16'h0B0B, 1'b0);
      idle();
      chk("t2_alarm", 32'(bus.alarm), 32'h1);
      release_alarm(1'b1);

      // cool samples without ack do not release
      raise(16'h0C01);
      repeat (20) drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("t3_no_ack_hold", 32'(bus.alarm),    32'h1);
      chk("t3_shutdown",    32'(bus.shutdown), 32'(SD_AFTER_LONG));
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (7) drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("t3_after7", 32'(bus.alarm), 32'h1);
      drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("t3_after8", 32'(bus.alarm), 32'h0);

      // ack with a simultaneous cool sample, then a hot sample restarts the release run
      raise(16'h0D02);
      drive(1'b1, 1'b0, 16'h0, 1'b1);
      repeat (5) drive(1'b1, 1'b0, 16'h0, 1'b0);
      drive(1'b1, 1'b1, 16'h0, 1'b0);
      repeat (7) drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("t4_after7", 32'(bus.alarm), 32'h1);
      drive(1'b1, 1'b0, 16'h0, 1'b0);
      idle();
      chk("t4_after8",    32'(bus.alarm),    32'h0);
      chk("t4_id_in_idle", 32'(bus.alarm_id), 32'h0D02);

      // invalid-sample gaps do not break the run; reset mid-alarm
      drive(1'b1, 1'b1, 16'h0, 1'b0);
      idle();
      drive(1'b1, 1'b1, 16'h0, 1'b0);
      idle();
      idle();
      drive(1'b1, 1'b1, 16'h0, 1'b0);
      idle();
      push_alarm(16'h0E03);
      drive(1'b1, 1'b1, 16'h0E03, 1'b0);
      idle();
      chk("t5_gap_alarm", 32'(bus.alarm), 32'h1);
      idle();
      do_reset();

      // event counter saturation
      for (int i = 0; i < 256; i++) begin
         raise(16'h1000 + 16'(i));
         release_alarm(1'b1);
      end
      chk("sat_event_count", 32'(bus.event_count), 32'd255);

`ifdef OTA_TIMEOUT_EN
      do_reset();
      raise(16'h0F0F);
      repeat (9) idle();
      chk("to_before", 32'(bus.shutdown), 32'h0);
      idle();
      chk("to_fire", 32'(bus.shutdown), 32'h1);
      release_alarm(1'b1);
      chk("to_sticky", 32'(bus.shutdown), 32'h1);

      do_reset();
      raise(16'h0F10);
      repeat (3) idle();
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (20) idle();
      chk("to_acked_alarm",    32'(bus.alarm),    32'h1);
      chk("to_acked_shutdown", 32'(bus.shutdown), 32'h0);
      release_alarm(1'b0);
`endif

      repeat (3) idle();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
